// File: rtl/sseg_mux_driver.sv
// Eight-digit multiplexed seven-segment driver with frame-synchronous value update.
// Outputs are registered one cycle behind the scan state to avoid anode overlap glitches.
module sseg_mux_driver #(
  parameter int COUNT_MAX = 100000,
  parameter bit LZ_BLANK  = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] value,
  input  logic        load,
  input  logic [7:0]  dp_en,
  output logic [6:0]  segments,
  output logic        dp,
  output logic [7:0]  anodes,
  output logic        frame_done
);

  localparam int TW = $clog2(COUNT_MAX);
  localparam logic [TW-1:0] TICK_LAST = TW'(COUNT_MAX - 1);

  logic [TW-1:0] tick;
  logic [2:0]    index;
  logic [31:0]   pending;
  logic [31:0]   active;
  logic          flag;

  logic          tick_wrap;
  logic          boundary;
  logic [3:0]    nibble;
  logic [6:0]    seg_code;
  logic          blank;
  logic [7:0]    anode_code;

  assign tick_wrap = (tick == TICK_LAST);
  assign boundary  = tick_wrap && (index == 3'd7);

  always_ff @(posedge clk) begin
    if (rst) begin
      tick  <= '0;
      index <= 3'd0;
    end else begin
      tick <= tick_wrap ? '0 : tick + 1'b1;
      if (tick_wrap) begin
        index <= index + 3'd1;
      end
    end
  end

  // A load on the boundary cycle bypasses pending so it shows in the very next frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= 32'd0;
      active  <= 32'd0;
      flag    <= 1'b0;
    end else begin
      if (load) begin
        pending <= value;
      end
      if (boundary) begin
        if (load) begin
          active <= value;
        end else if (flag) begin
          active <= pending;
        end
        flag <= 1'b0;
      end else if (load) begin
        flag <= 1'b1;
      end
    end
  end

  assign nibble = active[{index, 2'b00} +: 4];

  always_comb begin
    seg_code = 7'b1111111;
    case (nibble)
      4'h0: seg_code = 7'b0000001;
      4'h1: seg_code = 7'b1001111;
      4'h2: seg_code = 7'b0010010;
      4'h3: seg_code = 7'b0000110;
      4'h4: seg_code = 7'b1001100;
      4'h5: seg_code = 7'b0100100;
      4'h6: seg_code = 7'b0100000;
      4'h7: seg_code = 7'b0001111;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0000100;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b1100000;
      4'hC: seg_code = 7'b0110001;
      4'hD: seg_code = 7'b1000010;
      4'hE: seg_code = 7'b0110000;
      4'hF: seg_code = 7'b0111000;
      default: seg_code = 7'b1111111;
    endcase
  end

  // A digit is a leading zero when it and every more significant nibble is zero.
  assign blank      = LZ_BLANK && (index != 3'd0) && ((active >> {index, 2'b00}) == 32'd0);
  assign anode_code = blank ? 8'hFF : ~(8'd1 << index);

  always_ff @(posedge clk) begin
    if (rst) begin
      segments   <= 7'b1111111;
      anodes     <= 8'hFF;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      segments   <= blank ? 7'b1111111 : seg_code;
      anodes     <= anode_code;
      dp         <= ~dp_en[index];
      frame_done <= boundary;
    end
  end

endmodule
